// File: rtl/pixel_readout.sv
`default_nettype none
// ============================================================================
// Module   : pixel_readout
// Purpose  : Captures a pixel row from the column-parallel DATA bus while the
//            row's READ line is high. It commits the row when READ drops and
//            buffers committed rows in a two-entry ping-pong FIFO. Rows are
//            streamed out one byte per cycle over valid/ready, with SOF/EOF
//            frame markers and sticky OVERFLOW / READ_ERR flags.
// Ports    : CLOCK      - clock, rising edge
//            RESET      - asynchronous reset, active low
//            ERASE      - synchronous frame clear, active high
//            READ       - row-select lines (one-hot or zero)
//            DATA       - column data, byte c at DATA[8c+7:8c]
//            OUT_DATA   - streamed pixel byte
//            OUT_VALID  - OUT_DATA/OUT_SOF/OUT_EOF valid
//            OUT_READY  - sink accepts the byte
//            OUT_SOF    - byte is row 0, column 0
//            OUT_EOF    - byte is row ROWS-1, column COLS-1
//            OVERFLOW   - sticky, a committed row was dropped
//            READ_ERR   - sticky, a non-one-hot READ was committed
// Revision : 1.0 - initial release
// ============================================================================
module pixel_readout #(
  parameter int COLS = 4,
  parameter int ROWS = 4
) (
  input  logic                CLOCK,
  input  logic                RESET,
  input  logic                ERASE,
  input  logic [ROWS-1:0]     READ,
  input  logic [COLS*8-1:0]   DATA,
  output logic [7:0]          OUT_DATA,
  output logic                OUT_VALID,
  input  logic                OUT_READY,
  output logic                OUT_SOF,
  output logic                OUT_EOF,
  output logic                OVERFLOW,
  output logic                READ_ERR
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  // Shadow capture
  logic [COLS*8-1:0]       shadow_q, shadow_d;
  logic [ROWS-1:0]         read_q, read_d;
  // Two-entry row buffer
  logic [1:0][COLS*8-1:0]  mem_q, mem_d;
  logic [1:0][RW-1:0]      row_q, row_d;
  logic [1:0]              full_q, full_d;
  logic                    rd_ptr_q, rd_ptr_d;
  logic                    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]           col_q, col_d;
  // Sticky flags
  logic                    overflow_q, overflow_d;
  logic                    read_err_q, read_err_d;
  // Registered output stage
  logic [7:0]              out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_sof_q, out_sof_d;
  logic                    out_eof_q, out_eof_d;

  logic                    xfer, last_xfer, commit, onehot, slot_free;
  logic [RW-1:0]           row_idx;

  always_comb begin
    xfer      = out_valid_q && OUT_READY;
    last_xfer = xfer && (col_q == CW'(COLS - 1));
    commit    = (read_q != '0) && (READ == '0);
    onehot    = (read_q != '0) && ((read_q & (read_q - ROWS'(1))) == '0);
    row_idx   = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (read_q[r]) row_idx = RW'(r);
    end
    // With both entries full, rd_ptr == wr_ptr, so popping the head frees
    // exactly the entry the new row is aimed at.
    slot_free = !full_q[wr_ptr_q] || (last_xfer && (rd_ptr_q == wr_ptr_q));
  end

  always_comb begin
    shadow_d   = shadow_q;
    read_d     = READ;
    mem_d      = mem_q;
    row_d      = row_q;
    full_d     = full_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    col_d      = col_q;
    overflow_d = overflow_q;
    read_err_d = read_err_q;

    if (READ != '0) shadow_d = DATA;

    if (xfer) begin
      if (last_xfer) begin
        col_d            = '0;
        full_d[rd_ptr_q] = 1'b0;
        rd_ptr_d         = ~rd_ptr_q;
      end else begin
        col_d = col_q + CW'(1);
      end
    end

    if (commit) begin
      if (!onehot) begin
        read_err_d = 1'b1;
      end else if (slot_free) begin
        mem_d[wr_ptr_q]  = shadow_q;
        row_d[wr_ptr_q]  = row_idx;
        full_d[wr_ptr_q] = 1'b1;
        wr_ptr_d         = ~wr_ptr_q;
      end else begin
        overflow_d = 1'b1;
      end
    end

    if (ERASE) begin
      shadow_d   = '0;
      read_d     = '0;
      full_d     = '0;
      rd_ptr_d   = 1'b0;
      wr_ptr_d   = 1'b0;
      col_d      = '0;
      overflow_d = 1'b0;
      read_err_d = 1'b0;
    end

    // Output registers are loaded from the next buffer state so a commit into
    // an idle buffer shows up on OUT_VALID in the following cycle.
    out_valid_d = full_d[rd_ptr_d];
    out_data_d  = '0;
    if (out_valid_d) begin
      for (int c = 0; c < COLS; c++) begin
        if (col_d == CW'(c)) out_data_d = mem_d[rd_ptr_d][c*8 +: 8];
      end
    end
    out_sof_d = out_valid_d && (row_d[rd_ptr_d] == '0) && (col_d == '0);
    out_eof_d = out_valid_d && (row_d[rd_ptr_d] == RW'(ROWS - 1)) &&
                (col_d == CW'(COLS - 1));
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      shadow_q    <= '0;
      read_q      <= '0;
      mem_q       <= '0;
      row_q       <= '0;
      full_q      <= '0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      col_q       <= '0;
      overflow_q  <= 1'b0;
      read_err_q  <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_eof_q   <= 1'b0;
    end else begin
      shadow_q    <= shadow_d;
      read_q      <= read_d;
      mem_q       <= mem_d;
      row_q       <= row_d;
      full_q      <= full_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      col_q       <= col_d;
      overflow_q  <= overflow_d;
      read_err_q  <= read_err_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_sof_q   <= out_sof_d;
      out_eof_q   <= out_eof_d;
    end
  end

  assign OUT_DATA  = out_data_q;
  assign OUT_VALID = out_valid_q;
  assign OUT_SOF   = out_sof_q;
  assign OUT_EOF   = out_eof_q;
  assign OVERFLOW  = overflow_q;
  assign READ_ERR  = read_err_q;

endmodule
`default_nettype wire

// File: tb/tb_pixel_readout.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_readout
// Purpose  : Scoreboard bench for pixel_readout. Stimulus pushes the expected
//            {sof, eof, byte} for every row it expects to stream, and a
//            negedge monitor pops and compares on each accepted byte.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pixel_readout;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b0;
  logic        ERASE = 1'b0;
  logic [3:0]  READ  = '0;
  logic [31:0] DATA  = '0;
  logic [7:0]  OUT_DATA;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b1;
  logic        OUT_SOF, OUT_EOF, OVERFLOW, READ_ERR;

  int checks   = 0;
  int failures = 0;
  logic [9:0] exp_q[$];

  pixel_readout #(.COLS(4), .ROWS(4)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .ERASE(ERASE), .READ(READ), .DATA(DATA),
    .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_SOF(OUT_SOF), .OUT_EOF(OUT_EOF), .OVERFLOW(OVERFLOW),
    .READ_ERR(READ_ERR)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic push_row(input int row, input logic [31:0] d);
    for (int c = 0; c < 4; c++) begin
      exp_q.push_back({(row == 0 && c == 0), (row == 3 && c == 3), d[c*8 +: 8]});
    end
  endtask

  // Hold READ for n cycles, then drop it; returns after the commit cycle.
  task automatic read_row(input int row, input logic [31:0] d, input int n);
    READ = 4'b0001 << row;
    DATA = d;
    repeat (n) tick();
    READ = '0;
    DATA = 32'hDEADBEEF;
    tick();
  endtask

  task automatic drain(input string name);
    int budget = 60;
    while (exp_q.size() != 0 && budget > 0) begin
      tick();
      budget--;
    end
    check(name, exp_q.size(), 0);
    repeat (6) tick();
  endtask

  // Scoreboard monitor
  always @(negedge CLOCK) begin
    if (RESET && OUT_VALID && OUT_READY) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_byte actual=%h required=none", OUT_DATA);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        check("stream_byte", {22'd0, OUT_SOF, OUT_EOF, OUT_DATA}, {22'd0, e});
      end
    end
  end

  initial begin
    // Reset
    repeat (3) tick();
    check("rst_valid", OUT_VALID, 0);
    check("rst_data", OUT_DATA, 0);
    check("rst_flags", {OUT_SOF, OUT_EOF, OVERFLOW, READ_ERR}, 0);
    RESET = 1'b1;
    tick();

    // Single row, sink ready
    READ = 4'b0001;
    DATA = 32'h44332211;
    repeat (3) tick();
    READ = '0;
    DATA = 32'hDEADBEEF;
    push_row(0, 32'h44332211);
    check("commit_cycle_valid", OUT_VALID, 0);
    tick();
    check("latency_valid", OUT_VALID, 1);
    check("latency_data", OUT_DATA, 32'h11);
    drain("single_row_drain");

    // Full frame, rows in order
    for (int r = 0; r < 4; r++) begin
      logic [31:0] d;
      d = 32'h03020100 + r * 32'h10101010;
      push_row(r, d);
      read_row(r, d, 1);
      repeat (4) tick();
    end
    drain("frame_drain");
    check("frame_overflow", OVERFLOW, 0);

    // Backpressure and overflow
    OUT_READY = 1'b0;
    push_row(0, 32'hA3A2A1A0);
    read_row(0, 32'hA3A2A1A0, 1);
    check("stall_valid0", OUT_VALID, 1);
    check("stall_data0", OUT_DATA, 32'hA0);
    push_row(1, 32'hB3B2B1B0);
    read_row(1, 32'hB3B2B1B0, 2);
    check("stall_data1", OUT_DATA, 32'hA0);
    check("stall_sof1", OUT_SOF, 1);
    check("no_overflow_2rows", OVERFLOW, 0);
    read_row(2, 32'hC3C2C1C0, 1);
    check("stall_data2", OUT_DATA, 32'hA0);
    check("overflow_set", OVERFLOW, 1);
    OUT_READY = 1'b1;
    drain("overflow_drain");
    check("overflow_sticky", OVERFLOW, 1);
    ERASE = 1'b1;
    tick();
    ERASE = 1'b0;
    check("erase_overflow", OVERFLOW, 0);

    // Same-cycle release: commit lands on the head's last-byte acceptance
    OUT_READY = 1'b0;
    push_row(0, 32'h13121110);
    read_row(0, 32'h13121110, 1);
    push_row(1, 32'h23222120);
    read_row(1, 32'h23222120, 1);
    push_row(2, 32'h33323130);
    OUT_READY = 1'b1;            // col0 accepted this cycle
    tick();                      // col1
    tick();
    READ = 4'b0100;              // col2 accepted, row 2 captured
    DATA = 32'h33323130;
    tick();
    READ = '0;                   // commit while col3 is accepted
    DATA = 32'hDEADBEEF;
    tick();
    check("release_overflow", OVERFLOW, 0);
    drain("release_drain");

    // Bad select
    READ = 4'b0011;
    DATA = 32'h55555555;
    tick();
    READ = '0;
    tick();
    check("bad_sel_err", READ_ERR, 1);
    check("bad_sel_valid", OUT_VALID, 0);
    ERASE = 1'b1;
    tick();
    ERASE = 1'b0;
    check("erase_read_err", READ_ERR, 0);
    repeat (6) tick();

    // Reset mid-stream
    push_row(1, 32'h67666564);
    read_row(1, 32'h67666564, 1);
    tick();
    tick();
    check("mid_byte2", OUT_DATA, 32'h66);
    void'(exp_q.pop_back());     // bytes 2 and 3 never transfer
    void'(exp_q.pop_back());
    #2 RESET = 1'b0;
    #1;
    check("async_reset_valid", OUT_VALID, 0);
    @(posedge CLOCK);
    #3 RESET = 1'b1;
    drain("post_reset_drain");
    check("post_reset_valid", OUT_VALID, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pixel_readout.md
# pixel_readout

Downstream consumer of the pixel array's row readout: captures the column-parallel 8-bit `DATA` bus while a row's `READ` line is asserted and commits the row when `READ` drops. Buffers committed rows in a two-entry ping-pong row buffer and streams them out one byte per cycle over a valid/ready interface, with frame markers and a sticky overflow flag. Sits between the pixel array/state controller and the off-chip or serializer interface.

## Interface
- `COLS`, default 4: pixels per row, i.e. bytes per committed row.
- `ROWS`, default 4: number of rows; width of `READ`.

Ports:
- `CLOCK` input, 1 bit: the block's only clock; all logic on the rising edge.
- `RESET` input, 1 bit: asynchronous, active-low reset.
- `ERASE` input, 1 bit: synchronous frame clear, active-high.
- `READ` input, `ROWS` bits: row-select lines from the state controller; one-hot or zero.
- `DATA` input, `COLS*8` bits: column data; byte c is `DATA[8c+7:8c]`.
- `OUT_DATA` output, 8 bits: streamed pixel byte.
- `OUT_VALID` output, 1 bit: `OUT_DATA`, `OUT_SOF` and `OUT_EOF` are valid.
- `OUT_READY` input, 1 bit: the sink accepts the byte.
- `OUT_SOF` output, 1 bit: the byte is row 0, column 0.
- `OUT_EOF` output, 1 bit: the byte is row `ROWS-1`, column `COLS-1`.
- `OVERFLOW` output, 1 bit: sticky; a committed row was dropped.
- `READ_ERR` output, 1 bit: sticky; a non-one-hot `READ` was committed.

## Operation
- **Shadow capture.** Each cycle `READ != 0`, the block registers `DATA` into a shadow register and `READ` into `read_q`.
- **Commit event.** A commit occurs in a cycle where `read_q != 0` and `READ == 0`.
  - Row index is the binary encoding of `read_q`.
  - If `read_q` is not one-hot, the row is discarded and `READ_ERR` is set.
- **Buffer write.** On commit, the shadow row plus its row index is written to a free buffer entry.
  - An entry counts as free if it is empty, or if its last byte is accepted in the same cycle (`OUT_VALID && OUT_READY` on column `COLS-1`).
  - If no entry is free, the row is dropped, `OVERFLOW` is set and the buffer contents are unchanged.
- **Output order.**
  - Entries drain in commit order (FIFO of depth 2).
  - Within a row, bytes go out in column order 0 to `COLS-1`.
  - The column counter advances only on `OUT_VALID && OUT_READY`. After column `COLS-1` it wraps to 0, frees the entry and advances to the other entry.
- **Handshake.**
  - While `OUT_VALID && !OUT_READY`, `OUT_DATA`, `OUT_SOF` and `OUT_EOF` hold stable.
  - `OUT_VALID` never drops without a transfer, except on `ERASE` or reset.
- **Frame markers.** `OUT_SOF` and `OUT_EOF` depend only on the row index and column. Rows are not reordered; the stream order is the arrival order.
- **ERASE.**
  - Empties both entries, resets the column counter and clears `OUT_VALID`, `OVERFLOW`, `READ_ERR`, the shadow and `read_q`.
  - Has priority over a commit or transfer in the same cycle; that commit is lost.
- **Reset.** `RESET` low asynchronously forces all state to the values below, including mid-stream and mid-READ. Operation resumes on the first rising edge after release.

## Timing
- Reset values: `OUT_DATA`=0, `OUT_VALID`=0, `OUT_SOF`=0, `OUT_EOF`=0, `OVERFLOW`=0, `READ_ERR`=0, both entries empty, column counter 0, `read_q`=0.
- Captured data is the `DATA` sampled on the last cycle `READ` was nonzero.
- Latency: commit in cycle T means the entry is written at the end of T. If the output is idle, `OUT_VALID` rises in T+1 with column 0.
- Throughput: one byte per cycle with `OUT_READY` held high. A row drains in `COLS` cycles, and back-to-back entries drain without a bubble.
- Outputs are registered; there is no combinational path from `OUT_READY` to `OUT_VALID` or `OUT_DATA`.
- `OVERFLOW` and `READ_ERR` are set at the end of the commit cycle and are visible in T+1.

## Test plan
- **Single row, sink ready.** Reset, then `READ`=4'b0001 for 3 cycles with `DATA`=32'h44332211, then `READ`=0.
  - Expect `OUT_VALID` one cycle after the commit cycle, bytes 11, 22, 33, 44 on consecutive cycles.
  - Expect `OUT_SOF` on byte 11 only and `OUT_EOF` never.
- **Full frame.** Rows 0 to 3 read in order, with the sink ready.
  - Expect 16 bytes in row/column order, `OUT_SOF` on the first and `OUT_EOF` on the last, and `OVERFLOW`=0.
- **Backpressure and overflow.** `OUT_READY`=0, then commit rows 0, 1 and 2.
  - Expect the first byte of row 0 held stable, `OVERFLOW`=1 after the third commit, and row 2 never appearing.
  - Then raise `OUT_READY`: expect exactly 8 bytes (rows 0 and 1).
- **Same-cycle release.** With both entries full, commit a row in the same cycle the last byte of the head entry is accepted.
  - Expect the row accepted, `OVERFLOW` remaining 0 and the new row streamed after the second entry.
- **Bad select.** Commit with `READ`=4'b0011, then `ERASE` for one cycle.
  - Expect no output, `READ_ERR`=1 after the commit, and `READ_ERR`=0 after `ERASE`.
- **Reset mid-stream.** Assert `RESET` low during byte 2 of a row.
  - Expect `OUT_VALID`=0 immediately (asynchronous) and no residual bytes after release.
